// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS mult/div sequencer owning the HI/LO registers
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int InstDataWidth = 32;

  typedef enum logic [1:0] {Idle, Calc, Fix} stateT;

  stateT state, nextState;

  // op[1] selects divide, op[0]=0 selects the signed flavour
  logic                       opDiv;
  logic                       signA, signB, divZero;
  logic [InstDataWidth-1:0]   magA, magB;
  logic [2*InstDataWidth-1:0] acc;
  logic [4:0]                 count;

  logic accept, iterate, commit, hiLoWrite;

  logic [InstDataWidth-1:0]   absA, absB;
  logic [InstDataWidth:0]     mulSum;
  logic [InstDataWidth+1:0]   divDiff;
  logic [2*InstDataWidth-1:0] mulStep, divStep, prodFixed;
  logic [InstDataWidth-1:0]   quo, rem, resHi, resLo;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= Idle;
    else     state <= nextState;
  end

  // Next-state: cancel wins, a zero divisor skips straight to the fix-up
  always_comb begin
    nextState = state;
    if (cancel) begin
      nextState = Idle;
    end else begin
      case (state)
        Idle:    if (start) nextState = (op[1] && src_b == '0) ? Fix : Calc;
        Calc:    if (count == 5'd31) nextState = Fix;
        Fix:     nextState = Idle;
        default: nextState = Idle;
      endcase
    end
  end

  // FSM outputs and datapath enables
  always_comb begin
    busy      = (state != Idle);
    stall     = (state != Idle) | (start & (state == Idle));
    accept    = (state == Idle) & start & ~cancel;
    hiLoWrite = (state == Idle) & ~start & ~cancel;
    iterate   = (state == Calc) & ~cancel;
    commit    = (state == Fix) & ~cancel;
  end

  // Operand magnitudes, one shift-add / restoring-subtract step, and sign fix-up
  always_comb begin
    absA = (~op[0] & src_a[31]) ? (~src_a + 32'd1) : src_a;
    absB = (~op[0] & src_b[31]) ? (~src_b + 32'd1) : src_b;

    // Multiply: multiplier sits in acc low half and shifts out as product bits shift in
    mulSum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, magA} : 33'd0);
    mulStep = {mulSum, acc[31:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}
    divDiff = {1'b0, acc[63:31]} - {2'b00, magB};
    divStep = divDiff[33] ? {acc[62:0], 1'b0} : {divDiff[31:0], acc[30:0], 1'b1};

    quo       = acc[31:0];
    rem       = acc[63:32];
    prodFixed = (signA ^ signB) ? (~acc + 64'd1) : acc;
    if (opDiv) begin
      resLo = (signA ^ signB) ? (~quo + 32'd1) : quo;
      resHi = signA ? (~rem + 32'd1) : rem;
    end else begin
      resLo = prodFixed[31:0];
      resHi = prodFixed[63:32];
    end
  end

  // Datapath registers, HI/LO commit and mthi/mtlo writes
  always_ff @(posedge clk) begin
    if (rst) begin
      opDiv    <= 1'b0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      divZero  <= 1'b0;
      magA     <= '0;
      magB     <= '0;
      acc      <= '0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= commit;
      div_zero <= commit & opDiv & divZero;
      if (accept) begin
        opDiv   <= op[1];
        signA   <= ~op[0] & src_a[31];
        signB   <= ~op[0] & src_b[31];
        divZero <= op[1] & (src_b == '0);
        magA    <= absA;
        magB    <= absB;
        acc     <= {32'd0, op[1] ? absA : absB};
        count   <= '0;
      end
      if (iterate) begin
        count <= count + 5'd1;
        acc   <= opDiv ? divStep : mulStep;
      end
      if (commit && !(opDiv && divZero)) begin
        hi <= resHi;
        lo <= resLo;
      end
      if (hiLoWrite) begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;

  logic        clk, rst, start, cancel, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wr_data;
  logic        stall, busy, done, div_zero;
  logic [31:0] hi, lo;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .stall(stall), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
  } expT;

  expT         expQ[$];
  logic [31:0] mHi, mLo;
  int          passCnt, totalCnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (expQ.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        expT e;
        e = expQ.pop_front();
        check("hi", 64'(hi), 64'(e.h));
        check("lo", 64'(lo), 64'(e.l));
        check("div_zero", 64'(div_zero), 64'(e.dz));
      end
    end
  end

  // Reference: plain 64-bit arithmetic on the architectural operands
  task automatic doOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input bit midStart, input bit wrLoWith);
    expT         e;
    logic [63:0] p, q, r;
    longint      sa, sb;
    int          edges;
    bit          seen, stallOk;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    e.h  = mHi;
    e.l  = mLo;
    e.dz = 1'b0;
    case (o)
      2'b00: begin p = 64'(sa * sb); e.h = p[63:32]; e.l = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; e.h = p[63:32]; e.l = p[31:0]; end
      2'b10: begin
        if (b == 0) e.dz = 1'b1;
        else begin q = 64'(sa / sb); r = 64'(sa % sb); e.l = q[31:0]; e.h = r[31:0]; end
      end
      default: begin
        if (b == 0) e.dz = 1'b1;
        else begin q = {32'd0, a} / {32'd0, b}; r = {32'd0, a} % {32'd0, b}; e.l = q[31:0]; e.h = r[31:0]; end
      end
    endcase
    if (!e.dz) begin mHi = e.h; mLo = e.l; end
    expQ.push_back(e);

    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    wr_lo = wrLoWith; wr_data = 32'hDEADBEEF;
    #1 stallOk = stall;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = midStart && (edges == 5);
      wr_lo = 1'b0;
      if (start) begin op = 2'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom; end
      #1;
      if (done) seen = 1'b1;
      else if (!stall) stallOk = 1'b0;
    end
    check("latency", 64'(edges), (o[1] && b == 0) ? 64'd2 : 64'd34);
    check("stall_held", 64'(stallOk), 64'd1);
    check("stall_low_in_done", 64'(stall), 64'd0);
  endtask

  task automatic writeHiLo(input bit h, input bit l, input logic [31:0] d);
    @(negedge clk);
    wr_hi = h; wr_lo = l; wr_data = d;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    if (h) mHi = d;
    if (l) mLo = d;
    check("hi_after_write", 64'(hi), 64'(mHi));
    check("lo_after_write", 64'(lo), 64'(mLo));
  endtask

  task automatic startRaw(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    passCnt = 0; totalCnt = 0;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wr_data = '0;
    mHi = '0; mLo = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and combinational stall
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("idle_stall", 64'(stall), 64'd0);
    start = 1'b1; cancel = 1'b1; #1;
    check("stall_follows_start", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_blocks_start", 64'(busy), 64'd0);

    // Directed arithmetic cases
    doOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    doOp(2'b00, 32'hFFFFFFFD, 32'd7, 0, 0);
    doOp(2'b00, 32'h80000000, 32'h80000000, 0, 0);
    doOp(2'b10, 32'hFFFFFFF9, 32'd2, 0, 0);
    doOp(2'b11, 32'd100, 32'd7, 0, 0);
    doOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0);

    // Divide by zero keeps preloaded HI/LO; coincident wr_lo is dropped
    writeHiLo(1, 0, 32'h11);
    writeHiLo(0, 1, 32'h22);
    doOp(2'b11, 32'd5, 32'd0, 0, 1);
    doOp(2'b10, 32'd5, 32'd0, 0, 0);

    // Write together with cancel in IDLE is dropped
    @(negedge clk);
    cancel = 1'b1; wr_hi = 1'b1; wr_data = 32'hCAFE0000;
    @(negedge clk);
    cancel = 1'b0; wr_hi = 1'b0;
    check("cancel_drops_write", 64'(hi), 64'(mHi));
    writeHiLo(1, 1, 32'h5A5A1234);

    // Start while busy is ignored
    doOp(2'b11, 32'd100, 32'd7, 1, 0);

    // Cancel at count 10 during mult
    startRaw(2'b00, 32'h12345678, 32'h9ABCDEF0);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("cancel_hi", 64'(hi), 64'(mHi));
    check("cancel_lo", 64'(lo), 64'(mLo));

    // Reset mid-CALC, then a fresh divide
    writeHiLo(1, 1, 32'h77777777);
    startRaw(2'b01, 32'h00010001, 32'h00020003);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mHi = '0; mLo = '0;
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    doOp(2'b11, 32'd9, 32'd3, 0, 0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'h0;
        2: b = 32'hFFFFFFFF;
        3: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      doOp(2'($urandom_range(0, 3)), a, b, bit'($urandom_range(0, 1)), 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide sequencer serving the MIPS `mult`, `multu`, `div`, `divu` instructions and owning the architectural HI/LO registers read by `mfhi`/`mflo` and written by `mthi`/`mtlo`. It sits beside the EX-stage ALU. It accepts one operation from the decoder/EX stage, holds the pipeline with a stall request while it iterates, and commits results to HI/LO. It uses radix-2 shift-add and restoring shift-subtract, 32 iterations, on operand magnitudes, with a final sign fix-up.

## Interface
Parameters:
- none; the datapath is fixed at 32 bits (`InstDataWidth` width).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request an operation; sampled only in IDLE.
- `op`  in  2  operation: 00 `mult`, 01 `multu`, 10 `div`, 11 `divu`.
- `src_a`  in  32  rs value: multiplicand or dividend.
- `src_b`  in  32  rt value: multiplier or divisor.
- `cancel`  in  1  abort the in-flight operation (pipeline flush).
- `wr_hi`, `wr_lo`  in  1 each  `mthi`/`mtlo` write strobes.
- `wr_data`  in  32  data for `wr_hi`/`wr_lo`.
- `stall`  out  1  combinational; holds the pipeline.
- `busy`  out  1  registered; high when state ≠ IDLE.
- `done`  out  1  one-cycle pulse when HI/LO are committed.
- `div_zero`  out  1  pulses with `done` when a divisor of 0 was seen.
- `hi`, `lo`  out  32 each  architectural HI/LO registers.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, edge with `start`=1:
  - latch `op` and the signs of `src_a`/`src_b`;
  - latch |src_a| and |src_b| (magnitude for signed ops, raw for unsigned; |0x80000000| = 0x80000000 as unsigned);
  - clear the accumulator and set count=0.
  - Next state: CALC, or FIX directly if the op is a divide and `src_b`=0.
- CALC: one iteration per edge, count increments. After the edge with count==31 (32 iterations), go to FIX.
  - Multiply: 64-bit product of the magnitudes via shift-add.
  - Divide: restoring division, giving quotient and remainder magnitudes.
- FIX: one edge. Apply signs, write HI/LO, pulse `done`, return to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ. HI = product[63:32], LO = product[31:0].
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign. LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0 (two's-complement wrap; no trap).
  - Divide by zero: HI/LO unchanged, `div_zero`=1 for the same cycle as `done`.
- `stall` = (state≠IDLE) | (`start` & state==IDLE). It is low in the cycle `done` is high.
- `start` while not IDLE is ignored. The decoder does not issue it because of `stall`.
- `wr_hi`/`wr_lo` take effect on the edge only in IDLE and only when `start`=0. Otherwise they are dropped. Both may be asserted together.
- `cancel`, any state: next state IDLE; HI/LO unchanged; no `done`; no `div_zero`. `cancel` in IDLE also suppresses a coincident `start` and any coincident write.
- `rst` has priority over everything: state IDLE, HI=LO=0, count=0, `busy`=`done`=`div_zero`=0.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0. `stall` follows `start` combinationally.
- Normal op, `start` sampled at edge E0:
  - `busy`=1 after E0 through E33;
  - CALC spans E1..E32;
  - FIX at E33: HI/LO updated and `done`=1 for the cycle after E33;
  - a new `start` is accepted at E34 (no back-to-back at E33).
- Divide by zero: FIX at E1; `done` and `div_zero` high for the cycle after E1.
- `mfhi`/`mflo` reading in the `done` cycle sees the new values (outputs are registers).

## Test plan
- `multu` with 0xFFFFFFFF, 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, `done` exactly 34 edges after the `start` edge, `stall` high throughout.
- `mult` -3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. `mult` 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- `div` -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. `divu` 100 / 7 -> LO=14, HI=2. `div` 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- `divu` 5 / 0 with HI=0x11, LO=0x22 preloaded via `mthi`/`mtlo` -> `done`+`div_zero` after 2 edges; HI/LO stay 0x11/0x22.
- `cancel` at count 10 during `mult` -> IDLE next edge, no `done`, HI/LO unchanged. `start` while busy is ignored. `wr_lo` coincident with `start` is dropped.
- `rst` mid-CALC -> HI=LO=0, `busy`=0 next cycle; a fresh `divu` 9 / 3 then gives LO=3, HI=0.
